if_id_fifo: RTL and testbench

IF_ID_FIFO -- requirements
Module: if_id_fifo

---
 rtl/if_id_fifo.sv | 90 +++++++++
 tb/tb_if_id_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_fifo.sv
`default_nettype none
// ============================================================================
// if_id_fifo : first-word fall-through buffer between the IF and ID stages.
// Rev 1.0
// ============================================================================
module if_id_fifo #(
   parameter int              XLEN     = 32,
   parameter int              ILEN     = 32,
   parameter int              DEPTH    = 2,
   parameter logic [ILEN-1:0] NOP_INST = 32'h00000013
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         if_valid,
   input  logic [XLEN-1:0]              if_pc,
   input  logic [ILEN-1:0]              if_is,
   output logic                         if_ready,
   output logic                         id_valid,
   output logic [XLEN-1:0]              id_pc,
   output logic [ILEN-1:0]              id_is,
   input  logic                         id_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int            c_PW   = $clog2(DEPTH);
   localparam int            c_CW   = $clog2(DEPTH+1);
   localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

   logic [XLEN-1:0] mem_pc_q [DEPTH];
   logic [ILEN-1:0] mem_is_q [DEPTH];

   logic [c_PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [c_PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [c_CW-1:0] count_q,  count_d;

   logic w_push;
   logic w_pop;

   // Handshake readiness comes from registered occupancy only.
   assign if_ready = (count_q != c_FULL);
   assign id_valid = (count_q != '0);
   assign w_push   = if_valid && if_ready && !flush;
   assign w_pop    = id_valid && id_ready && !flush;

   assign id_pc    = id_valid ? mem_pc_q[rd_ptr_q] : '0;
   assign id_is    = id_valid ? mem_is_q[rd_ptr_q] : NOP_INST;
   assign count    = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (w_push) wr_ptr_d = wr_ptr_q + c_PW'(1);
         if (w_pop)  rd_ptr_d = rd_ptr_q + c_PW'(1);
         case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CW'(1);
            2'b01:   count_d = count_q - c_CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately unreset; id_valid masks stale contents.
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_pc_q[wr_ptr_q] <= if_pc;
         mem_is_q[wr_ptr_q] <= if_is;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_if_id_fifo.sv
`default_nettype none
// ============================================================================
// tb_if_id_fifo : scoreboard bench, DEPTH=2/XLEN=32 and DEPTH=4/XLEN=64 DUTs.
// Rev 1.0
// ============================================================================
module tb_if_id_fifo;

   localparam logic [31:0] c_NOP = 32'h00000013;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] is;
   } ent_t;

   typedef struct packed {
      logic [2:0]  cnt;
      logic        valid;
      logic [63:0] pc;
      logic [31:0] is;
      logic        rdy;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        if_valid;
   logic [63:0] if_pc;
   logic [31:0] if_is;
   logic        id_ready;

   logic        if_ready_a, id_valid_a;
   logic [31:0] id_pc_a, id_is_a;
   logic [1:0]  count_a;
   logic        if_ready_b, id_valid_b;
   logic [63:0] id_pc_b;
   logic [31:0] id_is_b;
   logic [2:0]  count_b;

   int n_chk  = 0;
   int n_pass = 0;

   ent_t refa_q[$];
   ent_t refb_q[$];
   exp_t expa_q[$];
   exp_t expb_q[$];

   if_id_fifo #(.XLEN(32), .ILEN(32), .DEPTH(2)) u_dut_a (
      .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid),
      .if_pc(if_pc[31:0]), .if_is(if_is), .if_ready(if_ready_a),
      .id_valid(id_valid_a), .id_pc(id_pc_a), .id_is(id_is_a),
      .id_ready(id_ready), .count(count_a)
   );

   if_id_fifo #(.XLEN(64), .ILEN(32), .DEPTH(4)) u_dut_b (
      .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid),
      .if_pc(if_pc), .if_is(if_is), .if_ready(if_ready_b),
      .id_valid(id_valid_b), .id_pc(id_pc_b), .id_is(id_is_b),
      .id_ready(id_ready), .count(count_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      else
         n_pass++;
   endtask

   // One clock of stimulus: record what each DUT should show this cycle,
   // then advance the reference queues by the coming edge.
   task automatic cycle(input bit v, input logic [63:0] pc, input logic [31:0] is,
                        input bit rdy, input bit fl);
      exp_t e;
      bit   acc, pp;
      @(negedge clk);
      if_valid = v; if_pc = pc; if_is = is; id_ready = rdy; flush = fl;

      e.cnt   = 3'(refa_q.size());
      e.valid = (refa_q.size() != 0);
      e.pc    = e.valid ? refa_q[0].pc : 64'h0;
      e.is    = e.valid ? refa_q[0].is : c_NOP;
      e.rdy   = (refa_q.size() != 2);
      expa_q.push_back(e);
      acc = v && !fl && (refa_q.size() < 2);
      pp  = rdy && !fl && (refa_q.size() > 0);
      if (fl) refa_q.delete();
      else begin
         if (pp)  void'(refa_q.pop_front());
         if (acc) refa_q.push_back('{pc: {32'h0, pc[31:0]}, is: is});
      end

      e.cnt   = 3'(refb_q.size());
      e.valid = (refb_q.size() != 0);
      e.pc    = e.valid ? refb_q[0].pc : 64'h0;
      e.is    = e.valid ? refb_q[0].is : c_NOP;
      e.rdy   = (refb_q.size() != 4);
      expb_q.push_back(e);
      acc = v && !fl && (refb_q.size() < 4);
      pp  = rdy && !fl && (refb_q.size() > 0);
      if (fl) refb_q.delete();
      else begin
         if (pp)  void'(refb_q.pop_front());
         if (acc) refb_q.push_back('{pc: pc, is: is});
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_a_count"},  64'(count_a),    64'h0);
      chk({tag, "_a_valid"},  64'(id_valid_a), 64'h0);
      chk({tag, "_a_pc"},     64'(id_pc_a),    64'h0);
      chk({tag, "_a_is"},     64'(id_is_a),    64'(c_NOP));
      chk({tag, "_a_ready"},  64'(if_ready_a), 64'h1);
      chk({tag, "_b_count"},  64'(count_b),    64'h0);
      chk({tag, "_b_valid"},  64'(id_valid_b), 64'h0);
      chk({tag, "_b_pc"},     id_pc_b,         64'h0);
      chk({tag, "_b_ready"},  64'(if_ready_b), 64'h1);
   endtask

   // Reset asserted between edges; outputs must clear without a clock edge.
   task automatic mid_reset();
      @(negedge clk);
      if_valid = 1'b0; id_ready = 1'b0; flush = 1'b0;
      #6;
      rst = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      @(negedge clk);
      rst = 1'b1;
      refa_q.delete();
      refb_q.delete();
   endtask

   // Monitor: compares every recorded cycle shortly before the next edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #4;
         if (expa_q.size() > 0) begin
            e = expa_q.pop_front();
            chk("a_count", 64'(count_a),    64'(e.cnt));
            chk("a_valid", 64'(id_valid_a), 64'(e.valid));
            chk("a_pc",    64'(id_pc_a),    e.pc);
            chk("a_is",    64'(id_is_a),    64'(e.is));
            chk("a_ready", 64'(if_ready_a), 64'(e.rdy));
         end
         if (expb_q.size() > 0) begin
            e = expb_q.pop_front();
            chk("b_count", 64'(count_b),    64'(e.cnt));
            chk("b_valid", 64'(id_valid_b), 64'(e.valid));
            chk("b_pc",    id_pc_b,         e.pc);
            chk("b_is",    64'(id_is_b),    64'(e.is));
            chk("b_ready", 64'(if_ready_b), 64'(e.rdy));
         end
      end
   end

   initial begin
      rst = 1'b0; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
      if_pc = '0; if_is = '0;
      #1;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b1;

      // Single push, then two-deep fill with an extra offer, then drain.
      cycle(1, 64'h100, 32'h00500093, 0, 0);
      cycle(1, 64'h104, 32'h00600113, 0, 0);
      cycle(1, 64'h108, 32'h00700193, 0, 0);
      cycle(0, 64'h0,   32'h0,        1, 0);
      cycle(0, 64'h0,   32'h0,        1, 0);
      cycle(0, 64'h0,   32'h0,        1, 0);
      cycle(0, 64'h0,   32'h0,        1, 0);
      cycle(0, 64'h0,   32'h0,        0, 0);

      // Steady streaming at occupancy one.
      cycle(0, 64'h0, 32'h0, 0, 1);
      cycle(1, 64'h1FC, 32'h11111111, 0, 0);
      for (int k = 0; k < 8; k++)
         cycle(1, 64'h200 + 64'(4 * k), 32'h20000000 + 32'(k), 1, 0);
      cycle(0, 64'h0, 32'h0, 1, 0);

      // Full, then flush with a competing push and pop.
      cycle(1, 64'h400, 32'h0A000001, 0, 0);
      cycle(1, 64'h404, 32'h0A000002, 0, 0);
      cycle(1, 64'h500, 32'h0B000000, 1, 1);
      cycle(0, 64'h0,   32'h0,        0, 0);

      // DEPTH=4 fill with wide PCs.
      for (int k = 0; k < 5; k++)
         cycle(1, {32'hDEAD0000 + 32'(k), 32'h600 + 32'(4 * k)}, 32'hC0000000 + 32'(k), 0, 0);
      cycle(0, 64'h0, 32'h0, 0, 0);
      for (int k = 0; k < 5; k++)
         cycle(0, 64'h0, 32'h0, 1, 0);

      // Asynchronous reset while full, then first push becomes head.
      cycle(1, 64'h700, 32'h0D000001, 0, 0);
      cycle(1, 64'h704, 32'h0D000002, 0, 0);
      cycle(0, 64'h0,   32'h0,        0, 0);
      mid_reset();
      cycle(1, 64'h300, 32'h0E000000, 0, 0);
      cycle(0, 64'h0,   32'h0,        0, 0);

      for (int k = 0; k < 400; k++)
         cycle($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom,
               $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);

      @(negedge clk);
      #6;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
